// File: rtl/esc_pkg.sv
// Shared ESC PWM constants, decoder state encoding and result payload.
// Drive and receive sides both import this so the pulse/speed mapping stays in one place.
package esc_pkg;

  localparam int unsigned SPEED_W          = 11;
  localparam int unsigned SPEED_MUL        = 3;
  localparam int unsigned PULSE_OFFSET_DEF = 6251;
  localparam int unsigned MAX_HIGH_DEF     = 12800;
  localparam int unsigned STALE_CYC_DEF    = 1000000;

  localparam int unsigned CNT_W = 14;
  localparam int unsigned DIV_W = 13;
  localparam int unsigned REM_W = 2;
  localparam int unsigned WD_W  = 20;

  typedef enum logic [2:0] {
    IDLE,
    MEAS,
    DIV,
    DONE,
    WAIT_LOW
  } dec_state_e;

  typedef struct packed {
    logic [SPEED_W-1:0] speed;
    logic [REM_W-1:0]   rem;
    logic               range_err;
  } dec_result_t;

  // One restoring step of divide-by-3: returns {quotient_bit, new_remainder}.
  function automatic logic [REM_W:0] div3_step(input logic [REM_W-1:0] r, input logic b);
    logic [REM_W:0] t;
    t = {r, b};
    if (t >= 3'd3) return {1'b1, 2'(t - 3'd3)};
    return {1'b0, t[REM_W-1:0]};
  endfunction

endpackage

// File: rtl/esc_pwm_decoder_if.sv
// Decoder pulse input and result bus; master is the decoder, slave is the consumer.
interface esc_pwm_decoder_if;
  import esc_pkg::*;

  logic               pwm_in;
  logic [SPEED_W-1:0] speed;
  logic [REM_W-1:0]   rem;
  logic               vld;
  logic               range_err;
  logic               timeout_err;
  logic               stale;

  modport master (
    input  pwm_in,
    output speed, rem, vld, range_err, timeout_err, stale
  );

  modport slave (
    output pwm_in,
    input  speed, rem, vld, range_err, timeout_err, stale
  );

endinterface

// File: rtl/esc_div3.sv
// Sequential restoring divide-by-3: first bit resolved on start, done pulses 13 cycles later.
module esc_div3
  import esc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [REM_W-1:0] remainder
);

  logic [DIV_W-1:0] dvd_q;
  logic [DIV_W-1:0] quo_q;
  logic [REM_W-1:0] rem_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [REM_W-1:0] r_in_c;
  logic             b_in_c;
  logic [REM_W:0]   step_c;

  always_comb begin
    r_in_c = start ? '0 : rem_q;
    b_in_c = start ? dividend[DIV_W-1] : dvd_q[DIV_W-1];
    step_c = div3_step(r_in_c, b_in_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        dvd_q  <= {dividend[DIV_W-2:0], 1'b0};
        quo_q  <= {{(DIV_W-1){1'b0}}, step_c[REM_W]};
        rem_q  <= step_c[REM_W-1:0];
        cnt_q  <= 4'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        dvd_q <= {dvd_q[DIV_W-2:0], 1'b0};
        quo_q <= {quo_q[DIV_W-2:0], step_c[REM_W]};
        rem_q <= step_c[REM_W-1:0];
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'(DIV_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/esc_pwm_decoder.sv
// ESC PWM receiver: measures pulse high time, recovers the speed command and
// reports range, timeout and staleness status.
module esc_pwm_decoder
  import esc_pkg::*;
#(
  parameter int unsigned PULSE_OFFSET = PULSE_OFFSET_DEF,
  parameter int unsigned MAX_HIGH     = MAX_HIGH_DEF,
  parameter int unsigned STALE_CYC    = STALE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  esc_pwm_decoder_if.master  bus
);

  localparam logic [CNT_W-1:0] OFFSET_C    = CNT_W'(PULSE_OFFSET);
  localparam logic [CNT_W-1:0] MAX_C       = CNT_W'(MAX_HIGH);
  localparam logic [WD_W-1:0]  STALE_C     = WD_W'(STALE_CYC);
  localparam logic [DIV_W-1:0] SPEED_MAX_C = DIV_W'((1 << SPEED_W) - 1);

  logic ps_meta, ps, ps_d;
  logic rise_c, fall_c;

  dec_state_e state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             below_q;
  logic             cnt_load_c, cnt_inc_c, capture_c, emit_c, timeout_c;

  logic             below_c;
  logic [DIV_W-1:0] div_dividend_c;
  logic             div_done;
  logic [DIV_W-1:0] div_quo;
  logic [REM_W-1:0] div_rem;

  dec_result_t      res_q, res_c;
  logic             vld_q, timeout_q, stale_q;
  logic [WD_W-1:0]  wd_q, wd_inc_c;

  // Two-flop synchronizer plus edge-detect delay flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_meta <= 1'b0;
      ps      <= 1'b0;
      ps_d    <= 1'b0;
    end else begin
      ps_meta <= bus.pwm_in;
      ps      <= ps_meta;
      ps_d    <= ps;
    end
  end

  assign rise_c = ps & ~ps_d;
  assign fall_c = ~ps & ps_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_load_c = 1'b0;
    cnt_inc_c  = 1'b0;
    capture_c  = 1'b0;
    emit_c     = 1'b0;
    timeout_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_c) begin
          cnt_load_c = 1'b1;
          state_nxt  = MEAS;
        end
      end
      MEAS: begin
        // Timeout wins over a fall seen in the same cycle (W == MAX_HIGH).
        if (cnt_q == MAX_C) begin
          timeout_c = 1'b1;
          state_nxt = WAIT_LOW;
        end else if (fall_c) begin
          capture_c = 1'b1;
          state_nxt = DIV;
        end else if (ps) begin
          cnt_inc_c = 1'b1;
        end
      end
      DIV: begin
        if (div_done) begin
          emit_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:     state_nxt = IDLE;
      WAIT_LOW: if (!ps) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Underflow is detected by compare so the subtraction never wraps.
  assign below_c        = cnt_q < OFFSET_C;
  assign div_dividend_c = below_c ? '0 : DIV_W'(cnt_q - OFFSET_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      below_q <= 1'b0;
    end else begin
      if (cnt_load_c)     cnt_q <= CNT_W'(1);
      else if (cnt_inc_c) cnt_q <= cnt_q + CNT_W'(1);
      if (capture_c)      below_q <= below_c;
    end
  end

  esc_div3 u_div3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (capture_c),
    .dividend  (div_dividend_c),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    res_c.speed     = SPEED_W'(div_quo);
    res_c.rem       = div_rem;
    res_c.range_err = 1'b0;
    if (below_q) begin
      res_c.speed     = '0;
      res_c.rem       = '0;
      res_c.range_err = 1'b1;
    end else if (div_quo > SPEED_MAX_C) begin
      res_c.speed     = SPEED_W'(SPEED_MAX_C);
      res_c.range_err = 1'b1;
    end
  end

  assign wd_inc_c = wd_q + WD_W'(1);

  // Result registers load on the DIV->DONE transition so vld lands in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= STALE_C;
      stale_q   <= 1'b1;
    end else begin
      vld_q     <= emit_c;
      timeout_q <= timeout_c;
      if (emit_c) res_q <= res_c;
      if (emit_c) begin
        wd_q    <= '0;
        stale_q <= 1'b0;
      end else if (wd_q != STALE_C) begin
        wd_q    <= wd_inc_c;
        stale_q <= (wd_inc_c == STALE_C);
      end
    end
  end

  assign bus.speed       = res_q.speed;
  assign bus.rem         = res_q.rem;
  assign bus.range_err   = res_q.range_err;
  assign bus.vld         = vld_q;
  assign bus.timeout_err = timeout_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_esc_pwm_decoder.sv
// Directed bench for esc_pwm_decoder: arithmetic model of W = OFFSET + 3*SPEED
// checked every cycle, with hand-computed results pinned at each vld.
module tb_esc_pwm_decoder;

  localparam int OFF     = 6251;
  localparam int MAXH    = 12800;
  localparam int STALE   = 100;
  localparam int SPD_MAX = 2047;
  localparam int LOW_GAP = 40;

  logic clk = 1'b0;
  logic rst_n;

  esc_pwm_decoder_if bus ();

  esc_pwm_decoder #(
    .PULSE_OFFSET (OFF),
    .MAX_HIGH     (MAXH),
    .STALE_CYC    (STALE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Schedule written by the stimulus process.
  int exp_vld_cyc = -1;
  int exp_to_cyc  = -1;
  int sch_speed, sch_rem, sch_re;
  int lit_speed, lit_rem, lit_re;
  bit fin = 1'b0;

  // State owned by the compare process.
  int checks = 0, failures = 0, vld_seen = 0, last_vld = -1;
  int exp_speed = 0, exp_rem = 0, exp_re = 0;
  bit ev, et, exp_stale;

  function automatic void model(input int w, output int s, output int r, output int re);
    int d;
    if (w < OFF) begin
      s = 0; r = 0; re = 1;
    end else begin
      d = w - OFF;
      r = d % 3;
      if (d / 3 > SPD_MAX) begin s = SPD_MAX; re = 1; end
      else                 begin s = d / 3;   re = 0; end
    end
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (fin) begin
      chk("vld_count", vld_seen, 7);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (!rst_n) begin
      exp_speed = 0; exp_rem = 0; exp_re = 0; last_vld = -1;
      chk("rst_speed",   int'(bus.speed),       0);
      chk("rst_rem",     int'(bus.rem),         0);
      chk("rst_vld",     int'(bus.vld),         0);
      chk("rst_range",   int'(bus.range_err),   0);
      chk("rst_timeout", int'(bus.timeout_err), 0);
      chk("rst_stale",   int'(bus.stale),       1);
    end else begin
      ev = (cyc == exp_vld_cyc);
      et = (cyc == exp_to_cyc);
      if (ev) begin
        exp_speed = sch_speed; exp_rem = sch_rem; exp_re = sch_re; last_vld = cyc;
      end
      if (bus.vld) vld_seen++;
      exp_stale = (last_vld < 0) || (cyc - last_vld >= STALE);
      chk("vld",       int'(bus.vld),         int'(ev));
      chk("timeout",   int'(bus.timeout_err), int'(et));
      chk("speed",     int'(bus.speed),       exp_speed);
      chk("rem",       int'(bus.rem),         exp_rem);
      chk("range_err", int'(bus.range_err),   exp_re);
      chk("stale",     int'(bus.stale),       int'(exp_stale));
      if (ev) begin
        chk("lit_speed", int'(bus.speed),     lit_speed);
        chk("lit_rem",   int'(bus.rem),       lit_rem);
        chk("lit_range", int'(bus.range_err), lit_re);
      end
    end
  end

  // pwm_in high for w cycles; vld expected 16 cycles after pwm_in falls
  // (2 sync + 14), timeout 3 cycles after the count reaches MAXH.
  task automatic pulse(input int w, input int ls, input int lr, input int lre);
    int r, s, rm, re;
    @(posedge clk); #1;
    bus.pwm_in = 1'b1;
    r = cyc;
    if (w >= MAXH) exp_to_cyc = r + MAXH + 3;
    repeat (w) @(posedge clk);
    #1;
    bus.pwm_in = 1'b0;
    if (w < MAXH) begin
      model(w, s, rm, re);
      sch_speed = s; sch_rem = rm; sch_re = re;
      lit_speed = ls; lit_rem = lr; lit_re = lre;
      exp_vld_cyc = cyc + 16;
    end
    repeat (LOW_GAP) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    pulse(6251,  0,    0, 0);
    pulse(6256,  1,    2, 0);
    pulse(12800, 0,    0, 0);
    pulse(9251,  1000, 0, 0);
    pulse(12392, 2047, 0, 0);
    pulse(12799, 2047, 2, 1);
    pulse(6000,  0,    0, 1);

    // Reset while measuring: nothing may come out of the aborted pulse.
    @(posedge clk); #1;
    bus.pwm_in = 1'b1;
    repeat (2000) @(posedge clk);
    #1;
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LOW_GAP) @(posedge clk);

    // Reset while dividing: six cycles into DIV.
    @(posedge clk); #1;
    bus.pwm_in = 1'b1;
    repeat (6300) @(posedge clk);
    #1 bus.pwm_in = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LOW_GAP) @(posedge clk);

    pulse(6257, 2, 0, 0);
    repeat (200) @(posedge clk);
    fin = 1'b1;
  end

endmodule
